// File: rtl/cam_tx_pkg.sv
// Shared definitions for the RGB555 camera-style transmitter: FSM states,
// default timing and the two-byte pixel packing.
package cam_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VSYNC,
      ST_VBACK,
      ST_ACTIVE,
      ST_HBLANK
   } cam_state_e;

   localparam int DEF_H_ACTIVE    = 640;
   localparam int DEF_V_ACTIVE    = 480;
   localparam int DEF_H_BLANK     = 144;
   localparam int DEF_VSYNC_LINES = 3;
   localparam int DEF_VBACK_LINES = 17;

   localparam int COL_W  = 11;
   localparam int LINE_W = 10;

   // First byte on the wire: {0, R[4:0], G[4:3]} of the 5-bit components.
   function automatic logic [7:0] pack_byte0(input logic [4:0] r5, input logic [4:0] g5);
      return {1'b0, r5, g5[4:3]};
   endfunction

   function automatic logic [7:0] pack_byte1(input logic [4:0] g5, input logic [4:0] b5);
      return {g5[2:0], b5};
   endfunction

endpackage

// File: rtl/rgb555_pack_reg.sv
// One-entry pixel holding register with valid/ready handshake and the
// registered byte stream that follows the timing slots given by the top.
module rgb555_pack_reg
   import cam_tx_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] red,
   input  logic [7:0] green,
   input  logic [7:0] blue,
   input  logic       pix_valid,
   output logic       pix_ready,
   input  logic       byte0_slot,
   input  logic       byte1_slot,
   output logic [7:0] cam_data,
   output logic       underrun
);

   logic        full_q, full_d;
   logic [15:0] hold_q, hold_d;
   logic [7:0]  byte1_q, byte1_d;
   logic [7:0]  data_q, data_d;
   logic        underrun_q, underrun_d;
   logic        accept;

   // The low three bits of each colour are dropped by the RGB555 format.
   logic unused_low_bits;
   assign unused_low_bits = ^{red[2:0], green[2:0], blue[2:0]};

   assign accept = pix_valid && !full_q;

   // A byte0 slot drains the register; a fill in the same cycle wins.
   always_comb begin
      full_d     = full_q;
      hold_d     = hold_q;
      byte1_d    = byte1_q;
      data_d     = 8'h00;
      underrun_d = underrun_q;

      if (byte0_slot) begin
         full_d = 1'b0;
         if (full_q) begin
            data_d  = hold_q[15:8];
            byte1_d = hold_q[7:0];
         end else begin
            data_d     = 8'h00;
            byte1_d    = 8'h00;
            underrun_d = 1'b1;
         end
      end else if (byte1_slot) begin
         data_d = byte1_q;
      end

      if (accept) begin
         full_d = 1'b1;
         hold_d = {pack_byte0(red[7:3], green[7:3]), pack_byte1(green[7:3], blue[7:3])};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q     <= 1'b0;
         hold_q     <= 16'h0000;
         byte1_q    <= 8'h00;
         data_q     <= 8'h00;
         underrun_q <= 1'b0;
      end else begin
         full_q     <= full_d;
         hold_q     <= hold_d;
         byte1_q    <= byte1_d;
         data_q     <= data_d;
         underrun_q <= underrun_d;
      end
   end

   assign pix_ready = !full_q;
   assign cam_data  = data_q;
   assign underrun  = underrun_q;

endmodule

// File: rtl/rgb555_cam_tx.sv
// Camera-style RGB555 transmitter: frame/line timing FSM driving vsync/href,
// with pixels packed two bytes per pixel by rgb555_pack_reg.
module rgb555_cam_tx
   import cam_tx_pkg::*;
#(
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int H_BLANK     = DEF_H_BLANK,
   parameter int VSYNC_LINES = DEF_VSYNC_LINES,
   parameter int VBACK_LINES = DEF_VBACK_LINES
) (
   input  logic       Cam_pclk,
   input  logic       Reset,
   input  logic       Enable,
   input  logic [7:0] red,
   input  logic [7:0] green,
   input  logic [7:0] blue,
   input  logic       pix_valid,
   output logic       pix_ready,
   output logic       Cam_vsync,
   output logic       Cam_href,
   output logic [7:0] Cam_data,
   output logic       frame_start,
   output logic       underrun
);

   localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;

   localparam logic [COL_W-1:0]  ACT_LAST   = COL_W'(2 * H_ACTIVE - 1);
   localparam logic [COL_W-1:0]  BLANK_LAST = COL_W'(H_BLANK - 1);
   localparam logic [COL_W-1:0]  LINE_LAST  = COL_W'(LINE_LEN - 1);
   localparam logic [LINE_W-1:0] VSYNC_LAST = LINE_W'(VSYNC_LINES - 1);
   localparam logic [LINE_W-1:0] VBACK_LAST = LINE_W'(VBACK_LINES - 1);
   localparam logic [LINE_W-1:0] VACT_LAST  = LINE_W'(V_ACTIVE - 1);

   cam_state_e        state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              vsync_q, vsync_d;
   logic              href_q, href_d;
   logic              frame_start_q, frame_start_d;
   logic              byte0_slot, byte1_slot;

   // Outputs are registered from next-state values so they line up with the state.
   always_comb begin
      state_d       = state_q;
      col_d         = col_q;
      line_d        = line_q;
      frame_start_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (Enable) begin
               state_d       = ST_VSYNC;
               col_d         = '0;
               line_d        = '0;
               frame_start_d = 1'b1;
            end
         end
         ST_VSYNC: begin
            if (col_q == LINE_LAST) begin
               col_d = '0;
               if (line_q == VSYNC_LAST) begin
                  state_d = ST_VBACK;
                  line_d  = '0;
               end else begin
                  line_d = line_q + 1'b1;
               end
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         ST_VBACK: begin
            if (col_q == LINE_LAST) begin
               col_d = '0;
               if (line_q == VBACK_LAST) begin
                  state_d = ST_ACTIVE;
                  line_d  = '0;
               end else begin
                  line_d = line_q + 1'b1;
               end
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (col_q == ACT_LAST) begin
               state_d = ST_HBLANK;
               col_d   = '0;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         ST_HBLANK: begin
            if (col_q == BLANK_LAST) begin
               col_d = '0;
               if (line_q == VACT_LAST) begin
                  line_d = '0;
                  if (Enable) begin
                     state_d       = ST_VSYNC;
                     frame_start_d = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  line_d  = line_q + 1'b1;
                  state_d = ST_ACTIVE;
               end
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            col_d   = '0;
            line_d  = '0;
         end
      endcase

      vsync_d    = (state_d == ST_VSYNC);
      href_d     = (state_d == ST_ACTIVE);
      byte0_slot = href_d && !col_d[0];
      byte1_slot = href_d && col_d[0];
   end

   always_ff @(posedge Cam_pclk or posedge Reset) begin
      if (Reset) begin
         state_q       <= ST_IDLE;
         col_q         <= '0;
         line_q        <= '0;
         vsync_q       <= 1'b0;
         href_q        <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         line_q        <= line_d;
         vsync_q       <= vsync_d;
         href_q        <= href_d;
         frame_start_q <= frame_start_d;
      end
   end

   rgb555_pack_reg u_pack (
      .clk        (Cam_pclk),
      .rst        (Reset),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .byte0_slot (byte0_slot),
      .byte1_slot (byte1_slot),
      .cam_data   (Cam_data),
      .underrun   (underrun)
   );

   assign Cam_vsync   = vsync_q;
   assign Cam_href    = href_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_rgb555_cam_tx.sv
// Directed self-checking bench for rgb555_cam_tx using a small frame
// (4 pixels x 2 lines, 11-cycle line period, 44-cycle frame).
module tb_rgb555_cam_tx;

   localparam int FRAME_LEN = 44;

   logic       Cam_pclk  = 1'b0;
   logic       Reset     = 1'b0;
   logic       Enable    = 1'b0;
   logic [7:0] red       = 8'h00;
   logic [7:0] green     = 8'h00;
   logic [7:0] blue      = 8'h00;
   logic       pix_valid = 1'b0;
   logic       pix_ready;
   logic       Cam_vsync;
   logic       Cam_href;
   logic [7:0] Cam_data;
   logic       frame_start;
   logic       underrun;

   int tests_run    = 0;
   int tests_failed = 0;

   rgb555_cam_tx #(
      .H_ACTIVE    (4),
      .V_ACTIVE    (2),
      .H_BLANK     (3),
      .VSYNC_LINES (1),
      .VBACK_LINES (1)
   ) dut (
      .Cam_pclk    (Cam_pclk),
      .Reset       (Reset),
      .Enable      (Enable),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .Cam_vsync   (Cam_vsync),
      .Cam_href    (Cam_href),
      .Cam_data    (Cam_data),
      .frame_start (frame_start),
      .underrun    (underrun)
   );

   always #5 Cam_pclk = ~Cam_pclk;

   // Frame profile: t=0 is the first cycle after Enable is sampled.
   function automatic logic exp_vsync(input int t);
      return (t < 11);
   endfunction

   function automatic logic exp_href(input int t);
      return ((t >= 22) && (t < 30)) || ((t >= 33) && (t < 41));
   endfunction

   function automatic logic exp_byte0(input int t);
      if ((t >= 22) && (t < 30)) return ((t - 22) % 2) == 0;
      if ((t >= 33) && (t < 41)) return ((t - 33) % 2) == 0;
      return 1'b0;
   endfunction

   task automatic do_reset();
      Reset  = 1'b1;
      Enable = 1'b0;
      repeat (2) @(negedge Cam_pclk);
      Reset = 1'b0;
   endtask

   task automatic set_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      red   = r;
      green = g;
      blue  = b;
   endtask

   task automatic test_reset();
      #1 Reset = 1'b1;
      #1;
      tests_run += 6;
      if (Cam_vsync !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_vsync got %b expected 0", Cam_vsync); end
      if (Cam_href !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_href got %b expected 0", Cam_href); end
      if (Cam_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_data got %h expected 00", Cam_data); end
      if (frame_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_frame_start got %b expected 0", frame_start); end
      if (underrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_underrun got %b expected 0", underrun); end
      if (pix_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_pix_ready got %b expected 1", pix_ready); end
      @(negedge Cam_pclk);
      Reset = 1'b0;
   endtask

   task automatic test_idle_accept();
      pix_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge Cam_pclk);
         tests_run += 3;
         if (Cam_vsync !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_vsync i=%0d got %b expected 0", i, Cam_vsync); end
         if (frame_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_frame_start i=%0d got %b expected 0", i, frame_start); end
         if (pix_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL idle_pix_ready i=%0d got %b expected 1", i, pix_ready); end
      end
      set_pixel(8'hF8, 8'hFC, 8'hF8);
      pix_valid = 1'b1;
      @(negedge Cam_pclk);
      tests_run++;
      if (pix_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_accept_pix_ready got %b expected 0", pix_ready); end
   endtask

   // Pixel 0xF8/0xFC/0xF8 packs to 0x7F,0xFF.
   task automatic test_frame_timing();
      int fs_count;
      logic [7:0] exp_data;
      fs_count = 0;
      Enable = 1'b1;
      @(negedge Cam_pclk);
      Enable = 1'b0;
      for (int t = 0; t < FRAME_LEN + 4; t++) begin
         if (frame_start === 1'b1) fs_count++;
         exp_data = exp_href(t) ? (exp_byte0(t) ? 8'h7F : 8'hFF) : 8'h00;
         tests_run += 4;
         if (Cam_vsync !== exp_vsync(t)) begin tests_failed++; $display("[TB] FAIL frame_vsync t=%0d got %b expected %b", t, Cam_vsync, exp_vsync(t)); end
         if (Cam_href !== exp_href(t)) begin tests_failed++; $display("[TB] FAIL frame_href t=%0d got %b expected %b", t, Cam_href, exp_href(t)); end
         if (frame_start !== (t == 0)) begin tests_failed++; $display("[TB] FAIL frame_start t=%0d got %b expected %b", t, frame_start, (t == 0)); end
         if (Cam_data !== exp_data) begin tests_failed++; $display("[TB] FAIL frame_data t=%0d got %h expected %h", t, Cam_data, exp_data); end
         @(negedge Cam_pclk);
      end
      tests_run += 2;
      if (fs_count != 1) begin tests_failed++; $display("[TB] FAIL frame_start_count got %0d expected 1", fs_count); end
      if (underrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL frame_underrun got %b expected 0", underrun); end
   endtask

   // Pixel 0x08/0x24/0x10: R5=00001 G5=00100 B5=00010 -> 0x04 and {100,00010}=0x82.
   task automatic test_pack_b();
      logic [7:0] exp_data;
      set_pixel(8'h08, 8'h24, 8'h10);
      pix_valid = 1'b1;
      do_reset();
      Enable = 1'b1;
      @(negedge Cam_pclk);
      Enable = 1'b0;
      for (int t = 0; t < FRAME_LEN; t++) begin
         exp_data = exp_href(t) ? (exp_byte0(t) ? 8'h04 : 8'h82) : 8'h00;
         tests_run++;
         if (Cam_data !== exp_data) begin tests_failed++; $display("[TB] FAIL pack_b_data t=%0d got %h expected %h", t, Cam_data, exp_data); end
         @(negedge Cam_pclk);
      end
      tests_run++;
      if (underrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL pack_b_underrun got %b expected 0", underrun); end
   endtask

   task automatic test_underrun();
      pix_valid = 1'b0;
      do_reset();
      Enable = 1'b1;
      @(negedge Cam_pclk);
      Enable = 1'b0;
      for (int t = 0; t < FRAME_LEN + 4; t++) begin
         tests_run += 3;
         if (Cam_href !== exp_href(t)) begin tests_failed++; $display("[TB] FAIL underrun_href t=%0d got %b expected %b", t, Cam_href, exp_href(t)); end
         if (Cam_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL underrun_data t=%0d got %h expected 00", t, Cam_data); end
         if (underrun !== (t >= 22)) begin tests_failed++; $display("[TB] FAIL underrun_flag t=%0d got %b expected %b", t, underrun, (t >= 22)); end
         @(negedge Cam_pclk);
      end
   endtask

   task automatic test_back_to_back();
      int tt;
      logic ev, eh, ef;
      logic [7:0] ed;
      set_pixel(8'hF8, 8'hFC, 8'hF8);
      pix_valid = 1'b1;
      do_reset();
      Enable = 1'b1;
      @(negedge Cam_pclk);
      for (int t = 0; t < 2 * FRAME_LEN + 8; t++) begin
         if (t < 2 * FRAME_LEN) begin
            tt = t % FRAME_LEN;
            ev = exp_vsync(tt);
            eh = exp_href(tt);
            ef = (tt == 0);
            ed = eh ? (exp_byte0(tt) ? 8'h7F : 8'hFF) : 8'h00;
         end else begin
            ev = 1'b0;
            eh = 1'b0;
            ef = 1'b0;
            ed = 8'h00;
         end
         tests_run += 4;
         if (Cam_vsync !== ev) begin tests_failed++; $display("[TB] FAIL b2b_vsync t=%0d got %b expected %b", t, Cam_vsync, ev); end
         if (Cam_href !== eh) begin tests_failed++; $display("[TB] FAIL b2b_href t=%0d got %b expected %b", t, Cam_href, eh); end
         if (frame_start !== ef) begin tests_failed++; $display("[TB] FAIL b2b_frame_start t=%0d got %b expected %b", t, frame_start, ef); end
         if (Cam_data !== ed) begin tests_failed++; $display("[TB] FAIL b2b_data t=%0d got %h expected %h", t, Cam_data, ed); end
         if (t == 50) Enable = 1'b0;
         @(negedge Cam_pclk);
      end
   endtask

   task automatic test_reset_mid();
      set_pixel(8'hF8, 8'hFC, 8'hF8);
      pix_valid = 1'b1;
      do_reset();
      Enable = 1'b1;
      @(negedge Cam_pclk);
      Enable = 1'b0;
      repeat (25) @(negedge Cam_pclk);
      tests_run += 2;
      if (Cam_href !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_pre_href got %b expected 1", Cam_href); end
      if (Cam_data !== 8'hFF) begin tests_failed++; $display("[TB] FAIL mid_pre_data got %h expected ff", Cam_data); end
      Reset = 1'b1;
      #1;
      tests_run += 4;
      if (Cam_href !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_reset_href got %b expected 0", Cam_href); end
      if (Cam_vsync !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_reset_vsync got %b expected 0", Cam_vsync); end
      if (Cam_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL mid_reset_data got %h expected 00", Cam_data); end
      if (pix_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_reset_pix_ready got %b expected 1", pix_ready); end
      @(negedge Cam_pclk);
      Reset = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge Cam_pclk);
         tests_run += 3;
         if (Cam_vsync !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_reset_vsync i=%0d got %b expected 0", i, Cam_vsync); end
         if (Cam_href !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_reset_href i=%0d got %b expected 0", i, Cam_href); end
         if (frame_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_reset_frame_start i=%0d got %b expected 0", i, frame_start); end
      end
      Enable = 1'b1;
      @(negedge Cam_pclk);
      Enable = 1'b0;
      tests_run += 2;
      if (frame_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL restart_frame_start got %b expected 1", frame_start); end
      if (Cam_vsync !== 1'b1) begin tests_failed++; $display("[TB] FAIL restart_vsync got %b expected 1", Cam_vsync); end
   endtask

   initial begin
      test_reset();
      test_idle_accept();
      test_frame_timing();
      test_pack_b();
      test_underrun();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not complete");
   end

endmodule
